// File: rtl/pad_reader.sv
`timescale 1ns/1ps
// pad_reader: scans two DB9 joystick ports with a shared select line and
// decodes Mega Drive 3-button pads or one-button Atari sticks into
// active-high control bytes. Both bytes are committed together once per scan.
module pad_reader #(
    parameter int SETTLE = 8,
    parameter int PERIOD = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [5:0] pad1,
    input  logic [5:0] pad2,
    output logic       select,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic [1:0] present,
    output logic       strobe
);

    localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 2;
    localparam logic [TW-1:0] T_HI   = TW'(SETTLE);
    localparam logic [TW-1:0] T_LO   = TW'(2 * SETTLE + 1);
    localparam logic [TW-1:0] T_LAST = TW'(PERIOD - 1);

    typedef enum logic [1:0] {
        ST_HIGH   = 2'd0,
        ST_LOW    = 2'd1,
        ST_COMMIT = 2'd2,
        ST_IDLE   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tick;

    logic [5:0]    meta1;
    logic [5:0]    meta2;
    logic [5:0]    s1;
    logic [5:0]    s2;

    // High-phase sample keeps all six pins; low phase only needs
    // left/right (detection) and pin6/pin9 (A/start).
    logic [5:0]    hi1;
    logic [5:0]    hi2;
    logic [3:0]    lo1;
    logic [3:0]    lo2;

    logic          latch_hi;
    logic          latch_lo;
    logic          commit;
    logic [8:0]    dec1;
    logic [8:0]    dec2;

    // Raw active-low sample to {present, start, A, C, B, up, down, left, right}.
    // lo holds {pin9, pin6, right, left} from the select-low phase.
    function automatic logic [8:0] decode(input logic [5:0] hi, input logic [3:0] lo);
        logic md;
        logic up;
        logic dn;
        logic lf;
        logic rt;
        md = ~lo[0] & ~lo[1];
        up = ~hi[0];
        dn = ~hi[1];
        lf = ~hi[2];
        rt = ~hi[3];
        if (up && dn) begin
            up = 1'b0;
            dn = 1'b0;
        end
        if (lf && rt) begin
            lf = 1'b0;
            rt = 1'b0;
        end
        return {md, md & ~lo[3], md & ~lo[2], ~hi[5], ~hi[4], up, dn, lf, rt};
    endfunction

    // Scan sequencer: free-running tick, wraps every PERIOD enabled cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tick <= '0;
        end else if (ce) begin
            tick <= (tick == T_LAST) ? '0 : tick + TW'(1);
        end
    end

    // Two-flop synchronizers on the raw pins; idle level is all-ones.
    always_ff @(posedge clock) begin
        if (!reset) begin
            meta1 <= '1;
            meta2 <= '1;
            s1    <= '1;
            s2    <= '1;
        end else if (ce) begin
            meta1 <= pad1;
            meta2 <= pad2;
            s1    <= meta1;
            s2    <= meta2;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_HIGH;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic, driven purely by tick positions.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HIGH:   if (tick == T_HI)   state_nxt = ST_LOW;
            ST_LOW:    if (tick == T_LO)   state_nxt = ST_COMMIT;
            ST_COMMIT:                     state_nxt = ST_IDLE;
            ST_IDLE:   if (tick == T_LAST) state_nxt = ST_HIGH;
            default:                       state_nxt = ST_HIGH;
        endcase
    end

    // FSM outputs: one-cycle actions at the two sample points and the commit.
    always_comb begin
        latch_hi = 1'b0;
        latch_lo = 1'b0;
        commit   = 1'b0;
        case (state)
            ST_HIGH:   latch_hi = (tick == T_HI);
            ST_LOW:    latch_lo = (tick == T_LO);
            ST_COMMIT: commit   = 1'b1;
            default:   ;
        endcase
    end

    // Phase sample registers; contents only matter once a commit follows.
    always_ff @(posedge clock) begin
        if (ce && latch_hi) begin
            hi1 <= s1;
            hi2 <= s2;
        end
        if (ce && latch_lo) begin
            lo1 <= s1[5:2];
            lo2 <= s2[5:2];
        end
    end

    assign dec1 = decode(hi1, lo1);
    assign dec2 = decode(hi2, lo2);

    // Select pin, strobe and the atomically committed output bytes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            select  <= 1'b1;
            strobe  <= 1'b0;
            joy1    <= '0;
            joy2    <= '0;
            present <= '0;
        end else if (ce) begin
            strobe <= commit;
            if (latch_hi) begin
                select <= 1'b0;
            end else if (latch_lo) begin
                select <= 1'b1;
            end
            if (commit) begin
                joy1    <= dec1[7:0];
                joy2    <= dec2[7:0];
                present <= {dec2[8], dec1[8]};
            end
        end
    end

endmodule
